// File: rtl/ktms_mmio_master.sv
// rtl/ktms_mmio_master.sv - MMIO bus initiator: one host request at a time, parity-protected bus command, ack wait with timeout.

module capi_parity_gen #(
  parameter int width = 64
) (
  input  logic [width-1:0] i_d,
  output logic             o_p
);
  // Odd parity, so an all-zero field carries a set parity bit.
  assign o_p = ~^i_d;
endmodule

module ktms_mmio_master #(
  parameter int mmiobus_width  = 94,
  parameter int timeout_width  = 10,
  parameter int timeout_cycles = 1000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_v,
  output logic                     i_r,
  input  logic                     i_cfg,
  input  logic                     i_rnw,
  input  logic                     i_dw,
  input  logic [23:0]              i_addr,
  input  logic [63:0]              i_data,
  output logic [mmiobus_width-1:0] o_mmiobus,
  input  logic                     i_mmio_rd_v,
  input  logic [63:0]              i_mmio_rd_d,
  input  logic                     i_mmio_wr_v,
  output logic                     o_v,
  input  logic                     o_r,
  output logic                     o_rnw,
  output logic [63:0]              o_data,
  output logic                     o_err,
  output logic                     o_stray
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [timeout_width-1:0] tc = timeout_width'(timeout_cycles - 1);

  state_t                   state_q, state_d;
  logic                     cfg_q, cfg_d;
  logic                     rnw_q, rnw_d;
  logic                     dw_q, dw_d;
  logic [23:0]              addr_q, addr_d;
  logic [63:0]              data_q, data_d;
  logic [timeout_width-1:0] cnt_q, cnt_d;
  logic                     o_rnw_q, o_rnw_d;
  logic [63:0]              o_data_q, o_data_d;
  logic                     o_err_q, o_err_d;
  logic                     stray_q, stray_d;
  logic                     addr_par, data_par;
  logic                     ack_hit, ack_wrong;

  capi_parity_gen #(.width(24)) u_addr_par (.i_d(addr_q), .o_p(addr_par));
  capi_parity_gen #(.width(64)) u_data_par (.i_d(data_q), .o_p(data_par));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cfg_q    <= 1'b0;
      rnw_q    <= 1'b0;
      dw_q     <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      cnt_q    <= '0;
      o_rnw_q  <= 1'b0;
      o_data_q <= '0;
      o_err_q  <= 1'b0;
      stray_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cfg_q    <= cfg_d;
      rnw_q    <= rnw_d;
      dw_q     <= dw_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      cnt_q    <= cnt_d;
      o_rnw_q  <= o_rnw_d;
      o_data_q <= o_data_d;
      o_err_q  <= o_err_d;
      stray_q  <= stray_d;
    end
  end

  assign ack_hit   = rnw_q ? i_mmio_rd_v : i_mmio_wr_v;
  assign ack_wrong = rnw_q ? i_mmio_wr_v : i_mmio_rd_v;

  always_comb begin
    state_d  = state_q;
    cfg_d    = cfg_q;
    rnw_d    = rnw_q;
    dw_d     = dw_q;
    addr_d   = addr_q;
    data_d   = data_q;
    cnt_d    = cnt_q;
    o_rnw_d  = o_rnw_q;
    o_data_d = o_data_q;
    o_err_d  = o_err_q;
    stray_d  = i_mmio_rd_v | i_mmio_wr_v;
    case (state_q)
      IDLE: begin
        if (i_v) begin
          cfg_d   = i_cfg;
          rnw_d   = i_rnw;
          dw_d    = i_dw;
          addr_d  = i_addr;
          // Reads put zero data on the bus, so zero it at capture.
          data_d  = i_rnw ? 64'd0 : i_data;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d   = cnt_q + timeout_width'(1);
        stray_d = ack_wrong;
        if (ack_hit) begin
          o_rnw_d  = rnw_q;
          o_data_d = rnw_q ? i_mmio_rd_d : 64'd0;
          o_err_d  = 1'b0;
          state_d  = RESP;
        end else if (cnt_q == tc) begin
          o_rnw_d  = rnw_q;
          o_data_d = rnw_q ? {64{1'b1}} : 64'd0;
          o_err_d  = 1'b1;
          state_d  = RESP;
        end
      end
      RESP: begin
        if (o_r) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign i_r       = (state_q == IDLE);
  assign o_v       = (state_q == RESP);
  assign o_rnw     = o_rnw_q;
  assign o_data    = o_data_q;
  assign o_err     = o_err_q;
  assign o_stray   = stray_q;
  assign o_mmiobus = (state_q == ISSUE) ?
                     {1'b1, cfg_q, rnw_q, dw_q, addr_q, addr_par, data_q, data_par} :
                     '0;

endmodule

// File: tb/tb_ktms_mmio_master.sv
// tb/tb_ktms_mmio_master.sv - directed vector bench for ktms_mmio_master.

module tb_ktms_mmio_master;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_v, i_r, i_cfg, i_rnw, i_dw;
  logic [23:0] i_addr;
  logic [63:0] i_data;
  logic [93:0] o_mmiobus;
  logic        i_mmio_rd_v, i_mmio_wr_v;
  logic [63:0] i_mmio_rd_d;
  logic        o_v, o_r, o_rnw, o_err, o_stray;
  logic [63:0] o_data;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ktms_mmio_master #(.mmiobus_width(94), .timeout_width(10), .timeout_cycles(16)) dut (
    .clk(clk), .reset(reset), .i_v(i_v), .i_r(i_r), .i_cfg(i_cfg), .i_rnw(i_rnw),
    .i_dw(i_dw), .i_addr(i_addr), .i_data(i_data), .o_mmiobus(o_mmiobus),
    .i_mmio_rd_v(i_mmio_rd_v), .i_mmio_rd_d(i_mmio_rd_d), .i_mmio_wr_v(i_mmio_wr_v),
    .o_v(o_v), .o_r(o_r), .o_rnw(o_rnw), .o_data(o_data), .o_err(o_err), .o_stray(o_stray)
  );

  typedef struct {
    logic        cfg, rnw, dw;
    logic [23:0] addr;
    logic [63:0] data;
    int          delay;   // ack cycle relative to bus-valid cycle; 0 = never
    logic [63:0] rd_d;
    int          hold;    // cycles with o_r low before accepting
    int          lat;     // cycles from bus valid to o_v
    logic [63:0] exp_data;
    logic        exp_err, exp_ap, exp_dp;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_txn(input vec_t v);
    logic [63:0] bus_d;
    int          lat;
    bus_d = v.rnw ? 64'd0 : v.data;
    chk("i_r idle", i_r, 1'b1);
    i_v = 1'b1; i_cfg = v.cfg; i_rnw = v.rnw; i_dw = v.dw; i_addr = v.addr; i_data = v.data;
    tick();
    i_v = 1'b0;
    chk("bus issue", o_mmiobus, {1'b1, v.cfg, v.rnw, v.dw, v.addr, v.exp_ap, bus_d, v.exp_dp});
    chk("i_r busy", i_r, 1'b0);
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      i_mmio_rd_v = 1'b0; i_mmio_wr_v = 1'b0; i_mmio_rd_d = '0;
      if (k == 1) chk("bus clear", o_mmiobus, 94'd0);
      if (o_v) begin
        lat = k;
        break;
      end
      if (k == v.delay) begin
        if (v.rnw) begin
          i_mmio_rd_v = 1'b1; i_mmio_rd_d = v.rd_d;
        end else begin
          i_mmio_wr_v = 1'b1;
        end
      end
    end
    chk("latency", lat, v.lat);
    chk("o_rnw", o_rnw, v.rnw);
    chk("o_data", o_data, v.exp_data);
    chk("o_err", o_err, v.exp_err);
    chk("o_stray quiet", o_stray, 1'b0);
    if (v.hold > 0) begin
      repeat (v.hold) tick();
      chk("o_v held", o_v, 1'b1);
      chk("o_data held", o_data, v.exp_data);
      chk("i_r held low", i_r, 1'b0);
    end
    o_r = 1'b1;
    tick();
    o_r = 1'b0;
    chk("o_v drop", o_v, 1'b0);
    chk("i_r back", i_r, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ov_cnt;
    vecs[0] = '{1'b0, 1'b0, 1'b1, 24'h000100, 64'h0123456789ABCDEF, 2, 64'd0, 0, 3, 64'd0, 1'b0, 1'b0, 1'b1};
    vecs[1] = '{1'b0, 1'b1, 1'b1, 24'h000140, 64'h0, 3, 64'hDEADBEEF00000001, 5, 4, 64'hDEADBEEF00000001, 1'b0, 1'b1, 1'b1};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 24'hABCDEF, 64'h5A5A, 0, 64'd0, 0, 17, 64'hFFFFFFFFFFFFFFFF, 1'b1, 1'b0, 1'b1};
    vecs[3] = '{1'b1, 1'b0, 1'b0, 24'hFFFFFF, 64'h0000000000000001, 0, 64'd0, 0, 17, 64'd0, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 1'b0, 1'b1, 24'h000001, 64'hFFFFFFFFFFFFFFFF, 16, 64'd0, 0, 17, 64'd0, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{1'b1, 1'b1, 1'b1, 24'h000000, 64'h0, 1, 64'h5555AAAA5555AAAA, 2, 2, 64'h5555AAAA5555AAAA, 1'b0, 1'b1, 1'b1};

    reset = 1'b1; i_v = 1'b0; i_cfg = 1'b0; i_rnw = 1'b0; i_dw = 1'b0; i_addr = '0; i_data = '0;
    i_mmio_rd_v = 1'b0; i_mmio_wr_v = 1'b0; i_mmio_rd_d = '0; o_r = 1'b0;
    repeat (3) tick();
    chk("rst i_r", i_r, 1'b1);
    chk("rst bus", o_mmiobus, 94'd0);
    chk("rst o_v", o_v, 1'b0);
    chk("rst o_rnw", o_rnw, 1'b0);
    chk("rst o_data", o_data, 64'd0);
    chk("rst o_err", o_err, 1'b0);
    chk("rst o_stray", o_stray, 1'b0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 6; i++) do_txn(vecs[i]);

    // Stray read-valid while idle
    i_mmio_rd_v = 1'b1;
    tick();
    i_mmio_rd_v = 1'b0;
    chk("stray idle pulse", o_stray, 1'b1);
    tick();
    chk("stray idle end", o_stray, 1'b0);
    chk("stray idle i_r", i_r, 1'b1);
    chk("stray idle o_v", o_v, 1'b0);

    // Write ack during a pending read is ignored; later rd_v completes it
    i_v = 1'b1; i_rnw = 1'b1; i_cfg = 1'b0; i_dw = 1'b1; i_addr = 24'h000010;
    tick();
    i_v = 1'b0;
    tick();
    i_mmio_wr_v = 1'b1;
    tick();
    i_mmio_wr_v = 1'b0;
    chk("wrong-type stray", o_stray, 1'b1);
    chk("wrong-type no o_v", o_v, 1'b0);
    i_mmio_rd_v = 1'b1; i_mmio_rd_d = 64'h1122334455667788;
    tick();
    i_mmio_rd_v = 1'b0; i_mmio_rd_d = '0;
    chk("wrong-type o_v", o_v, 1'b1);
    chk("wrong-type o_data", o_data, 64'h1122334455667788);
    chk("wrong-type o_err", o_err, 1'b0);
    chk("wrong-type stray end", o_stray, 1'b0);
    o_r = 1'b1;
    tick();
    o_r = 1'b0;

    // Reset asserted during ISSUE clears the bus without a clock edge
    i_v = 1'b1; i_rnw = 1'b0; i_addr = 24'h000200; i_data = 64'hCAFE;
    tick();
    i_v = 1'b0;
    chk("pre-reset bus vld", o_mmiobus[93], 1'b1);
    #2 reset = 1'b1;
    #1;
    chk("async bus clear", o_mmiobus, 94'd0);
    chk("async i_r", i_r, 1'b1);
    tick();
    reset = 1'b0;
    tick();

    // Reset three cycles after ISSUE: no completion afterwards, late ack is stray
    i_v = 1'b1; i_rnw = 1'b1; i_addr = 24'h000300;
    tick();
    i_v = 1'b0;
    repeat (3) tick();
    #2 reset = 1'b1;
    #1;
    chk("wait-reset o_v", o_v, 1'b0);
    chk("wait-reset i_r", i_r, 1'b1);
    chk("wait-reset o_data", o_data, 64'd0);
    tick();
    reset = 1'b0;
    i_mmio_rd_v = 1'b1; i_mmio_rd_d = 64'h77;
    tick();
    i_mmio_rd_v = 1'b0; i_mmio_rd_d = '0;
    chk("post-reset stray", o_stray, 1'b1);
    ov_cnt = 0;
    for (int k = 0; k < 25; k++) begin
      tick();
      if (o_v) ov_cnt++;
    end
    chk("no completion after reset", ov_cnt, 0);
    do_txn(vecs[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
